// File: rtl/grad_class_pkg.sv
// ---------------------------------------------------------------------------
// grad_class_pkg
// Shared definitions for the gradient-direction classifier pipeline:
//   - NUM_CLASS    : number of edge classes produced
//   - grad_class_e : class encodings carried on out_class
//   - grad_width() : signed gradient width needed for a given pixel width
//                    and channel count
// ---------------------------------------------------------------------------
package grad_class_pkg;

    localparam int NUM_CLASS = 5;

    typedef enum logic [2:0] {
        CLS_FLAT = 3'd0,   // magnitude below the flatness threshold
        CLS_VPOS = 3'd1,   // vertical-dominant, gy >= 0
        CLS_HPOS = 3'd2,   // horizontal-dominant, gy >= 0
        CLS_VNEG = 3'd3,   // vertical-dominant, gy < 0
        CLS_HNEG = 3'd4    // horizontal-dominant, gy < 0
    } grad_class_e;

    // A 3-pixel sum needs PIX_W+2 bits, the difference of two such sums one
    // more for sign, and accumulating over channels adds clog2(nch).
    function automatic int grad_width(input int pix_w, input int nch);
        return pix_w + 3 + $clog2(nch);
    endfunction

endpackage

// File: rtl/grad_chan_diff.sv
// ---------------------------------------------------------------------------
// grad_chan_diff
// Combinational per-channel gradient terms of one 3x3 window.
// Ports:
//   win : 9 unsigned pixels, pixel k (row-major) at [k*PIX_W +: PIX_W]
//   h   : (P0+P3+P6) - (P2+P5+P8)   left column minus right column
//   v   : (P0+P1+P2) - (P6+P7+P8)   top row minus bottom row
//   x   : P3 - P5                   centre-row horizontal difference
//   y   : P1 - P7                   centre-column vertical difference
// ---------------------------------------------------------------------------
module grad_chan_diff #(
    parameter int PIX_W = 8,
    parameter int GW    = 11
) (
    input  logic        [9*PIX_W-1:0] win,
    output logic signed [GW-1:0]      h,
    output logic signed [GW-1:0]      v,
    output logic signed [GW-1:0]      x,
    output logic signed [GW-1:0]      y
);

    // Zero-extend each pixel into the signed gradient width so all
    // arithmetic below is exact.
    logic signed [GW-1:0] p [9];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            p[k] = $signed({{(GW - PIX_W){1'b0}}, win[k*PIX_W +: PIX_W]});
        end
    end

    assign h = (p[0] + p[3] + p[6]) - (p[2] + p[5] + p[8]);
    assign v = (p[0] + p[1] + p[2]) - (p[6] + p[7] + p[8]);
    assign x = p[3] - p[5];
    assign y = p[1] - p[7];

endmodule

// File: rtl/grad_class_pipe.sv
// ---------------------------------------------------------------------------
// grad_class_pipe
// Streaming 3-stage edge-direction classifier, one 3x3 multi-channel window
// per beat, with valid/ready flow control, frame tags, a per-frame latched
// flatness threshold and per-frame class histograms.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/ready  : input handshake (in_ready = global pipeline advance)
//   in_sof/in_eof   : frame tags of the input beat
//   win_in          : window, channel c pixel k at [(c*9+k)*PIX_W +: PIX_W]
//   thr_in          : flat threshold (FRAC_W fractional bits), taken on sof
//   out_valid/ready : output handshake
//   out_class       : class 0..4 (see grad_class_pkg)
//   out_sof/out_eof : frame tags aligned with out_class
//   hist_cnt        : completed-frame class counts, class n at n*CNT_W
//   hist_valid      : one-cycle pulse when hist_cnt has been refreshed
// ---------------------------------------------------------------------------
module grad_class_pipe
    import grad_class_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int THR_W  = 16,
    parameter int CNT_W  = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic                         in_eof,
    input  logic [NCH*9*PIX_W-1:0]       win_in,
    input  logic [THR_W-1:0]             thr_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_class,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic [NUM_CLASS*CNT_W-1:0]   hist_cnt,
    output logic                         hist_valid
);

    localparam int GW = grad_width(PIX_W, NCH);
    // Magnitude after alignment to the threshold's fixed-point scale, and a
    // compare width wide enough for both operands.
    localparam int MW = GW + 1 + FRAC_W;
    localparam int CW = (MW > THR_W) ? MW : THR_W;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    // Full-width magnitude: the most negative value maps to 2^(GW-1), which
    // still fits in GW unsigned bits.
    function automatic logic [GW-1:0] abs_gw(input logic signed [GW-1:0] a);
        return a[GW-1] ? $unsigned(-a) : $unsigned(a);
    endfunction

    function automatic logic [2:0] classify(
        input logic [GW:0]      mp,
        input logic [GW-1:0]    ax,
        input logic [GW-1:0]    ay,
        input logic             gy_neg,
        input logic [THR_W-1:0] thr
    );
        logic [CW-1:0] mag;
        logic [CW-1:0] lim;
        mag = CW'(mp) << FRAC_W;
        lim = CW'(thr);
        if (mag < lim)           return CLS_FLAT;
        else if (!gy_neg && ay >= ax) return CLS_VPOS;
        else if (!gy_neg)        return CLS_HPOS;
        else if (ay >= ax)       return CLS_VNEG;
        else                     return CLS_HNEG;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Flow control: every stage advances together or not at all.
    // -----------------------------------------------------------------------
    logic en;
    logic accept;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // -----------------------------------------------------------------------
    // Stage 1: per-channel h/v/x/y
    // -----------------------------------------------------------------------
    logic signed [GW-1:0] h_c [NCH];
    logic signed [GW-1:0] v_c [NCH];
    logic signed [GW-1:0] x_c [NCH];
    logic signed [GW-1:0] y_c [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        grad_chan_diff #(
            .PIX_W (PIX_W),
            .GW    (GW)
        ) u_diff (
            .win (win_in[c*9*PIX_W +: 9*PIX_W]),
            .h   (h_c[c]),
            .v   (v_c[c]),
            .x   (x_c[c]),
            .y   (y_c[c])
        );
    end

    logic signed [GW-1:0] h_p1 [NCH];
    logic signed [GW-1:0] v_p1 [NCH];
    logic signed [GW-1:0] x_p1 [NCH];
    logic signed [GW-1:0] y_p1 [NCH];
    logic [THR_W-1:0]     thr_p1;
    logic [THR_W-1:0]     thr_lat;
    logic                 vld_p1, sof_p1, eof_p1;

    // -----------------------------------------------------------------------
    // Stage 2: channel sums, magnitudes
    // -----------------------------------------------------------------------
    logic signed [GW-1:0] gh, gv, gx, gy;

    always_comb begin
        gh = '0;
        gv = '0;
        gx = '0;
        gy = '0;
        for (int c = 0; c < NCH; c++) begin
            gh = gh + h_p1[c];
            gv = gv + v_p1[c];
            gx = gx + x_p1[c];
            gy = gy + y_p1[c];
        end
    end

    logic [GW:0]      mp_p2;
    logic [GW-1:0]    ax_p2, ay_p2;
    logic             gy_neg_p2;
    logic [THR_W-1:0] thr_p2;
    logic             vld_p2, sof_p2, eof_p2;

    // -----------------------------------------------------------------------
    // Stage 3: classification
    // -----------------------------------------------------------------------
    logic [2:0] cls_p2;

    assign cls_p2 = classify(mp_p2, ax_p2, ay_p2, gy_neg_p2, thr_p2);

    // Datapath registers carry no reset; bubbles are tracked by the valids.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < NCH; c++) begin
                h_p1[c] <= h_c[c];
                v_p1[c] <= v_c[c];
                x_p1[c] <= x_c[c];
                y_p1[c] <= y_c[c];
            end
            // Each beat carries its own threshold so a new sof only affects
            // itself and the beats behind it.
            thr_p1    <= in_sof ? thr_in : thr_lat;

            mp_p2     <= {1'b0, abs_gw(gh)} + {1'b0, abs_gw(gv)};
            ax_p2     <= abs_gw(gx);
            ay_p2     <= abs_gw(gy);
            gy_neg_p2 <= gy[GW-1];
            thr_p2    <= thr_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_lat   <= '0;
            vld_p1    <= 1'b0;
            sof_p1    <= 1'b0;
            eof_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            sof_p2    <= 1'b0;
            eof_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_class <= 3'd0;
        end else begin
            if (accept && in_sof) begin
                thr_lat <= thr_in;
            end
            if (en) begin
                vld_p1    <= in_valid;
                sof_p1    <= in_valid && in_sof;
                eof_p1    <= in_valid && in_eof;
                vld_p2    <= vld_p1;
                sof_p2    <= sof_p1;
                eof_p2    <= eof_p1;
                out_valid <= vld_p2;
                out_sof   <= sof_p2;
                out_eof   <= eof_p2;
                // Hold the last class across bubbles so undefined stage-2
                // data never reaches the output register.
                if (vld_p2) begin
                    out_class <= cls_p2;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-frame class histogram
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] live     [NUM_CLASS];
    logic [CNT_W-1:0] live_nxt [NUM_CLASS];
    logic             fire;

    assign fire = out_valid && out_ready;

    always_comb begin
        for (int n = 0; n < NUM_CLASS; n++) begin
            live_nxt[n] = (fire && out_class == 3'(n)) ? sat_inc(live[n]) : live[n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CLASS; n++) begin
                live[n] <= '0;
            end
            hist_cnt   <= '0;
            hist_valid <= 1'b0;
        end else begin
            hist_valid <= 1'b0;
            if (fire && out_eof) begin
                // Publish counts including the eof beat, then restart.
                for (int n = 0; n < NUM_CLASS; n++) begin
                    hist_cnt[n*CNT_W +: CNT_W] <= live_nxt[n];
                    live[n]                    <= '0;
                end
                hist_valid <= 1'b1;
            end else begin
                for (int n = 0; n < NUM_CLASS; n++) begin
                    live[n] <= live_nxt[n];
                end
            end
        end
    end

endmodule
